// File: rtl/mem_arbiter_if.sv
// Core-side request/response and RAM-port signals of the memory arbiter.
// master: the arbiter itself; slave: the pipeline stages and the RAM it serves.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              iread;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              ihit;
  logic              dread;
  logic              dwrite;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dhit;
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_ready;

  modport master (
    input  iread, iaddr, dread, dwrite, daddr, dstore, ram_load, ram_ready,
    output iload, ihit, dload, dhit, ram_ren, ram_wen, ram_addr, ram_store
  );

  modport slave (
    output iread, iaddr, dread, dwrite, daddr, dstore, ram_load, ram_ready,
    input  iload, ihit, dload, dhit, ram_ren, ram_wen, ram_addr, ram_store
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: serializes fetch and load/store requests, data first.
// Optional MEM_ARB_PERF_EN adds saturating icount/dcount/wait_count outputs.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.master  bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]    icount,
  output logic [31:0]    dcount,
  output logic [31:0]    wait_count
`endif
);

  typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IRESP, DRESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  logic              wr_q;
  logic [DATA_W-1:0] iload_q, dload_q;
  logic              ihit_q, dhit_q;

  logic              ram_ren, ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;

  logic              data_req;
  assign data_req = bus.dread | bus.dwrite;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ihit_q <= (state == IBUSY) && bus.ram_ready;
      dhit_q <= (state == DBUSY) && bus.ram_ready;
      // Only one access is ever in flight, so fetch and data share the address latch.
      if (state == IDLE) begin
        if (data_req) begin
          addr_q  <= bus.daddr;
          store_q <= bus.dstore;
          wr_q    <= bus.dwrite;
        end else if (bus.iread) begin
          addr_q  <= bus.iaddr;
        end
      end
      if ((state == IBUSY) && bus.ram_ready)
        iload_q <= bus.ram_load;
      if ((state == DBUSY) && bus.ram_ready && !wr_q)
        dload_q <= bus.ram_load;
    end
  end

  always_comb begin
    state_nxt = state;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    case (state)
      IDLE: begin
        if (data_req)       state_nxt = DBUSY;
        else if (bus.iread) state_nxt = IBUSY;
      end
      IBUSY: begin
        ram_ren  = 1'b1;
        ram_addr = addr_q;
        if (bus.ram_ready) state_nxt = IRESP;
      end
      DBUSY: begin
        if (wr_q) begin
          ram_wen   = 1'b1;
          ram_store = store_q;
        end else begin
          ram_ren   = 1'b1;
        end
        ram_addr = addr_q;
        if (bus.ram_ready) state_nxt = DRESP;
      end
      IRESP:   state_nxt = IDLE;
      DRESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ram_ren   = ram_ren;
  assign bus.ram_wen   = ram_wen;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_store = ram_store;
  assign bus.iload     = iload_q;
  assign bus.dload     = dload_q;
  assign bus.ihit      = ihit_q;
  assign bus.dhit      = dhit_q;

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      icount     <= '0;
      dcount     <= '0;
      wait_count <= '0;
    end else begin
      if (ihit_q && (icount != '1))
        icount <= icount + 32'd1;
      if (dhit_q && (dcount != '1))
        dcount <= dcount + 32'd1;
      if (bus.iread && ((state == DBUSY) || (state == DRESP)) && (wait_count != '1))
        wait_count <= wait_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus reset/perf sequences.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] icount, dcount, wait_count;
`endif

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .icount     (icount),
    .dcount     (dcount),
    .wait_count (wait_count)
`endif
  );

  typedef struct {
    logic        iread;
    logic [31:0] iaddr;
    logic        dread;
    logic        dwrite;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] ram_load;
    logic        ram_ready;
    logic        e_ihit;
    logic        e_dhit;
    logic [31:0] e_iload;
    logic [31:0] e_dload;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t v(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl, input logic rdy,
    input logic eih, input logic edh, input logic [31:0] eil, input logic [31:0] edl,
    input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] es);
    vec_t r;
    r.iread = ir; r.iaddr = ia; r.dread = dr; r.dwrite = dw;
    r.daddr = da; r.dstore = ds; r.ram_load = rl; r.ram_ready = rdy;
    r.e_ihit = eih; r.e_dhit = edh; r.e_iload = eil; r.e_dload = edl;
    r.e_ren = er; r.e_wen = ew; r.e_addr = ea; r.e_store = es;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.iread = 1'b0; bus.iaddr = '0; bus.dread = 1'b0; bus.dwrite = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ram_load = '0; bus.ram_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_hit(input bit want_d, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = want_d ? bus.dhit : bus.ihit;
    end
    chk(nm, {31'd0, seen}, 32'd1);
  endtask

  localparam logic [31:0] IL  = 32'h00500093;
  localparam logic [31:0] DL1 = 32'h12345678;
  localparam logic [31:0] CF  = 32'hCAFEF00D;
  localparam logic [31:0] BF  = 32'h0BADF00D;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // fetch, zero wait
    tbl.push_back(v(0,0,            0,0,0,0,                      0,0,            0,0,0,0,        0,0,0,0));
    tbl.push_back(v(1,'h100,        0,0,0,0,                      IL,1,           0,0,0,0,        0,0,0,0));
    tbl.push_back(v(1,'h100,        0,0,0,0,                      IL,1,           0,0,0,0,        1,0,'h100,0));
    tbl.push_back(v(0,0,            0,0,0,0,                      IL,1,           1,0,IL,0,       0,0,0,0));
    tbl.push_back(v(0,0,            0,0,0,0,                      'hAAAA5555,0,   0,0,IL,0,       0,0,0,0));
    // store with 2 wait states; inputs change mid-access to prove latching
    tbl.push_back(v(0,0,            0,1,'h2000,'hDEADBEEF,        'hAAAA5555,0,   0,0,IL,0,       0,0,0,0));
    tbl.push_back(v(0,0,            0,1,'h2000,'hDEADBEEF,        'hAAAA5555,0,   0,0,IL,0,       0,1,'h2000,'hDEADBEEF));
    tbl.push_back(v(0,0,            0,1,'h3000,'h11111111,        'hAAAA5555,0,   0,0,IL,0,       0,1,'h2000,'hDEADBEEF));
    tbl.push_back(v(0,0,            0,1,'h2000,'hDEADBEEF,        'hAAAA5555,1,   0,0,IL,0,       0,1,'h2000,'hDEADBEEF));
    tbl.push_back(v(0,0,            0,0,0,0,                      'hAAAA5555,1,   0,1,IL,0,       0,0,0,0));
    tbl.push_back(v(0,0,            0,0,0,0,                      'hAAAA5555,1,   0,0,IL,0,       0,0,0,0));
    // contention: data first, fetch follows
    tbl.push_back(v(1,'h104,        1,0,'h40,0,                   DL1,1,          0,0,IL,0,       0,0,0,0));
    tbl.push_back(v(1,'h104,        1,0,'h40,0,                   DL1,1,          0,0,IL,0,       1,0,'h40,0));
    tbl.push_back(v(1,'h104,        0,0,0,0,                      DL1,1,          0,1,IL,DL1,     0,0,0,0));
    tbl.push_back(v(1,'h104,        0,0,0,0,                      CF,1,           0,0,IL,DL1,     0,0,0,0));
    tbl.push_back(v(1,'h104,        0,0,0,0,                      CF,1,           0,0,IL,DL1,     1,0,'h104,0));
    tbl.push_back(v(0,0,            0,0,0,0,                      CF,1,           1,0,CF,DL1,     0,0,0,0));
    tbl.push_back(v(0,0,            0,0,0,0,                      CF,1,           0,0,CF,DL1,     0,0,0,0));
    // dropped load request, completes after 2 waits
    tbl.push_back(v(0,0,            1,0,'h80,0,                   BF,0,           0,0,CF,DL1,     0,0,0,0));
    tbl.push_back(v(0,0,            0,0,0,0,                      BF,0,           0,0,CF,DL1,     1,0,'h80,0));
    tbl.push_back(v(0,0,            0,0,0,0,                      BF,0,           0,0,CF,DL1,     1,0,'h80,0));
    tbl.push_back(v(0,0,            0,0,0,0,                      BF,1,           0,0,CF,DL1,     1,0,'h80,0));
    tbl.push_back(v(0,0,            0,0,0,0,                      BF,1,           0,1,CF,BF,      0,0,0,0));
    tbl.push_back(v(1,'h200,        0,0,0,0,                      'h13,1,         0,0,CF,BF,      0,0,0,0));
    tbl.push_back(v(1,'h200,        0,0,0,0,                      'h13,1,         0,0,CF,BF,      1,0,'h200,0));
    tbl.push_back(v(0,0,            0,0,0,0,                      'h13,1,         1,0,'h13,BF,    0,0,0,0));
    tbl.push_back(v(0,0,            0,0,0,0,                      'h13,1,         0,0,'h13,BF,    0,0,0,0));
    // dread and dwrite together behave as a write
    tbl.push_back(v(0,0,            1,1,'h44,'h55AA55AA,          'h77777777,1,   0,0,'h13,BF,    0,0,0,0));
    tbl.push_back(v(0,0,            1,1,'h44,'h55AA55AA,          'h77777777,1,   0,0,'h13,BF,    0,1,'h44,'h55AA55AA));
    tbl.push_back(v(0,0,            0,0,0,0,                      'h77777777,1,   0,1,'h13,BF,    0,0,0,0));
    tbl.push_back(v(0,0,            0,0,0,0,                      'h77777777,1,   0,0,'h13,BF,    0,0,0,0));

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst           = 1'b0;
      bus.iread     = tbl[i].iread;
      bus.iaddr     = tbl[i].iaddr;
      bus.dread     = tbl[i].dread;
      bus.dwrite    = tbl[i].dwrite;
      bus.daddr     = tbl[i].daddr;
      bus.dstore    = tbl[i].dstore;
      bus.ram_load  = tbl[i].ram_load;
      bus.ram_ready = tbl[i].ram_ready;
      #1;
      chk($sformatf("r%0d ihit", i),      {31'd0, bus.ihit},    {31'd0, tbl[i].e_ihit});
      chk($sformatf("r%0d dhit", i),      {31'd0, bus.dhit},    {31'd0, tbl[i].e_dhit});
      chk($sformatf("r%0d iload", i),     bus.iload,            tbl[i].e_iload);
      chk($sformatf("r%0d dload", i),     bus.dload,            tbl[i].e_dload);
      chk($sformatf("r%0d ram_ren", i),   {31'd0, bus.ram_ren}, {31'd0, tbl[i].e_ren});
      chk($sformatf("r%0d ram_wen", i),   {31'd0, bus.ram_wen}, {31'd0, tbl[i].e_wen});
      chk($sformatf("r%0d ram_addr", i),  bus.ram_addr,         tbl[i].e_addr);
      chk($sformatf("r%0d ram_store", i), bus.ram_store,        tbl[i].e_store);
    end

    // reset during a write: strobes drop, no hit ever appears
    @(negedge clk);
    drive_idle();
    bus.dwrite = 1'b1; bus.daddr = 32'h2000; bus.dstore = 32'h1;
    step();
    chk("rstmid wen before", {31'd0, bus.ram_wen}, 32'd1);
    rst = 1'b1;
    step();
    chk("rstmid ren",   {31'd0, bus.ram_ren}, 32'd0);
    chk("rstmid wen",   {31'd0, bus.ram_wen}, 32'd0);
    chk("rstmid addr",  bus.ram_addr,         32'd0);
    chk("rstmid store", bus.ram_store,        32'd0);
    chk("rstmid ihit",  {31'd0, bus.ihit},    32'd0);
    chk("rstmid dhit",  {31'd0, bus.dhit},    32'd0);
    chk("rstmid iload", bus.iload,            32'd0);
    chk("rstmid dload", bus.dload,            32'd0);
    rst = 1'b0;
    drive_idle();
    bus.ram_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rstmid no dhit %0d", i), {31'd0, bus.dhit}, 32'd0);
    end

`ifdef MEM_ARB_PERF_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.iread = 1'b1; bus.iaddr = 32'h300;
    bus.dread = 1'b1; bus.daddr = 32'h48;
    bus.ram_ready = 1'b1; bus.ram_load = 32'h99;
    wait_hit(1'b1, "perf load dhit");
    bus.dread = 1'b0;
    wait_hit(1'b0, "perf fetch1 ihit");
    bus.iread = 1'b0;
    step();
    bus.iread = 1'b1; bus.iaddr = 32'h304;
    wait_hit(1'b0, "perf fetch2 ihit");
    bus.iread = 1'b0;
    step();
    chk("perf icount",     icount,     32'd2);
    chk("perf dcount",     dcount,     32'd1);
    chk("perf wait_count", wait_count, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter for the pipelined core.
- Accepts instruction-fetch requests from the fetch stage and load/store requests from the memory stage, and serializes them onto one RAM port.
- Returns one-cycle ihit/dhit pulses; these are the cache-hit inputs the hazard unit uses to stall or enable pipeline registers.
- Data requests take priority over fetches so the memory stage drains first.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width

Ports:
clk  input  1  core clock, all logic on rising edge
rst  input  1  synchronous active-high reset
iread  input  1  fetch request, held until ihit
iaddr  input  ADDR_W  fetch address
iload  output  DATA_W  fetched instruction, valid when ihit=1
ihit  output  1  fetch complete, one-cycle pulse
dread  input  1  load request, held until dhit
dwrite  input  1  store request, held until dhit
daddr  input  ADDR_W  data address
dstore  input  DATA_W  store data
dload  output  DATA_W  load data, valid when dhit=1
dhit  output  1  data access complete, one-cycle pulse
ram_ren  output  1  RAM read strobe
ram_wen  output  1  RAM write strobe
ram_addr  output  ADDR_W  RAM address
ram_store  output  DATA_W  RAM write data
ram_load  input  DATA_W  RAM read data, valid when ram_ready=1
ram_ready  input  1  RAM completes current access this cycle

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: state=IDLE; ihit=0, dhit=0, ram_ren=0, ram_wen=0; ram_addr, ram_store, iload, dload all 0.
- FSM states: IDLE, IBUSY, DBUSY, IRESP, DRESP.
- IDLE:
  - (dread|dwrite)=1 → DBUSY; latch daddr, dstore and op into internal regs.
  - Else iread=1 → IBUSY; latch iaddr.
  - Else stay in IDLE.
- IBUSY:
  - ram_ren=1, ram_addr=latched iaddr.
  - On ram_ready=1: capture ram_load into iload, go to IRESP.
- DBUSY:
  - dwrite op: ram_wen=1, ram_store=latched dstore.
  - dread op: ram_ren=1.
  - ram_addr=latched daddr.
  - On ram_ready=1: capture ram_load into dload (read only; dload unchanged on write), go to DRESP.
- IRESP: ihit=1 for exactly this cycle → IDLE. DRESP: dhit=1 for exactly this cycle → IDLE.
- Output timing: ram_ren/ram_wen/ram_addr/ram_store are combinational from state and latched regs, never from live request inputs. hit/load outputs are registered.
- Latency: request seen in IDLE at cycle N with ram_ready constantly 1 → hit at cycle N+2. Each extra RAM wait cycle adds 1.
- Back-to-back: after RESP the arbiter always returns to IDLE for one cycle so the requester can update its address. Minimum issue interval is 3 cycles.
- Simultaneous fetch and data request in IDLE: data served first; fetch waits in IDLE and is served next.
- dread and dwrite both asserted: treated as a write.
- Request dropped mid-transaction (e.g. pipeline flush): the access completes and the hit is still pulsed; the requester ignores it. Writes are never aborted.
- ram_ready while in IDLE/RESP: ignored.
- rst asserted in any state: next edge returns to IDLE with reset values. The in-flight access is abandoned with no hit, and the RAM strobes drop that same cycle.
- ihit and dhit are never asserted in the same cycle.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- When defined, adds outputs icount[31:0], dcount[31:0], wait_count[31:0]:
  - icount increments per ihit; dcount increments per dhit.
  - wait_count increments each cycle that iread=1 and the state is DBUSY or DRESP (fetch blocked by data).
  - All three cleared by rst; saturate at 32'hFFFFFFFF.
- When undefined, those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Fetch, zero wait: iread=1, iaddr=0x100, ram_ready=1, ram_load=0x00500093 → ram_ren=1 with ram_addr=0x100 at cycle 1; ihit=1, iload=0x00500093 at cycle 2; IDLE at cycle 3.
- Store with 2 wait states: dwrite=1, daddr=0x2000, dstore=0xDEADBEEF, ram_ready high on the 3rd BUSY cycle → ram_wen=1 held 3 cycles with stable addr/data; dhit pulses once; iload and dload unchanged.
- Contention: iread=1 and dread=1 in the same IDLE cycle, daddr=0x40 returns 0x12345678 → dhit first with dload=0x12345678, then ihit 3 cycles later. No overlap of ihit and dhit.
- Dropped request: dread asserted 1 cycle then deasserted, ram_ready after 2 cycles → dhit still pulses once; arbiter returns to IDLE and accepts the next iread.
- Reset mid-access: rst=1 during DBUSY with ram_wen=1 → next cycle all outputs 0, state IDLE, no dhit ever produced for that access.
- MEM_ARB_PERF_EN: 2 fetches, 1 load with iread held during the load → icount=2, dcount=1, wait_count equals the cycles spent in DBUSY plus DRESP.
